keypad_conditioner: RTL and testbench

Front-end stage that feeds the microwave controller.
- Synchronises and debounces the raw 10-key numeric keypad and the start/stop/clear push-buttons.
- Emits one-cycle one-hot digit strobes for the controller's keypad input.
- Drives the controller's active-low startn/stopn/clearn inputs with clean levels.
- Rejects multi-key presses and auto-repeat: one accepted press gives exactly one strobe.

---
 rtl/keypad_conditioner.sv | 149 ++++++++++++++
 tb/tb_keypad_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_conditioner.sv
// Purpose : synchronise + debounce 10 digit keys and start/stop/clear buttons; one strobe per accepted digit press.
// Latency : SYNC_STAGES+DEBOUNCE_CYCLES edges to a debounced level; digit strobe arrives one edge later.
// Backpressure: none; inputs are levels and outputs are strobes/levels that the controller must sample every cycle.
//
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   key_raw[9:0]                    - raw digit lines, bit i = digit i, 1 = pressed
//   start_raw, stop_raw, clear_raw  - raw push-buttons, 1 = pressed
//   keypad[9:0]                     - one-hot, single-cycle digit strobe
//   startn, stopn, clearn           - debounced button levels, active-low
//   multi_key                       - high while two or more digits are seen together (lockout)
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] key_raw,
  input  logic       start_raw,
  input  logic       stop_raw,
  input  logic       clear_raw,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       multi_key
);

  localparam int NUM_LINES = 13;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Line order: [9:0] digits, [10] start, [11] stop, [12] clear.
  logic [NUM_LINES-1:0] raw_lines;
  logic [NUM_LINES-1:0] synced_lines;
  logic [NUM_LINES-1:0] stable_lines;

  assign raw_lines = {clear_raw, stop_raw, start_raw, key_raw};

  // Synchroniser chain, one flop per stage per line.
  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw_lines;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced_lines = sync_q[SYNC_STAGES-1];

  // Per-line debounce: the synced value must disagree with the stable
  // value for DEBOUNCE_CYCLES consecutive cycles before stable flips.
  // Any cycle of agreement restarts the count.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else if (synced_lines[g] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= synced_lines[g];
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stable_lines[g] = stable_q;
  end

  // Buttons bypass the digit FSM; stable flops drive them directly.
  assign startn = ~stable_lines[10];
  assign stopn  = ~stable_lines[11];
  assign clearn = ~stable_lines[12];

  // Digit FSM
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [9:0] keypad_q;
  logic [9:0] keypad_d;
  logic [9:0] digits;
  logic       any_key;
  logic       one_hot;
  logic       multi;

  assign digits  = stable_lines[9:0];
  assign any_key = |digits;
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign one_hot = any_key && ((digits & (digits - 10'd1)) == 10'd0);
  assign multi   = any_key && !one_hot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      keypad_q <= '0;
    end else begin
      state_q  <= state_d;
      keypad_q <= keypad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (one_hot)    state_d = HELD;
        else if (multi) state_d = LOCKOUT;
      end
      HELD: begin
        if (!any_key)   state_d = IDLE;
        else if (multi) state_d = LOCKOUT;
      end
      LOCKOUT: begin
        if (!any_key)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe is only ever launched from IDLE, so holding a key or returning
  // to a single key from lockout never repeats it.
  always_comb begin
    keypad_d  = '0;
    multi_key = 1'b0;
    case (state_q)
      IDLE:    if (one_hot) keypad_d = digits;
      LOCKOUT: multi_key = 1'b1;
      default: ;
    endcase
  end

  assign keypad = keypad_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Purpose : self-checking bench for keypad_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// Latency : digit strobe expected 7 edges after the edge at which the raw input changes.
// Backpressure: none; a negedge monitor pops expected strobes from a queue as they appear.
module tb_keypad_conditioner;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] key_raw;
  logic       start_raw, stop_raw, clear_raw;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, multi_key;

  keypad_conditioner #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_raw),
    .start_raw (start_raw),
    .stop_raw  (stop_raw),
    .clear_raw (clear_raw),
    .keypad    (keypad),
    .startn    (startn),
    .stopn     (stopn),
    .clearn    (clearn),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  typedef struct {
    logic [9:0] val;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [9:0] keys;
    int         hold;
    logic [9:0] exp_strobe;
    logic       exp_multi;
  } vec_t;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_strobe(logic [9:0] v);
    exp_t e;
    e.val = v;
    e.at  = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0: start_raw = v;
      1: stop_raw  = v;
      default: clear_raw = v;
    endcase
  endtask

  function automatic logic btn_n(int b);
    case (b)
      0: return startn;
      1: return stopn;
      default: return clearn;
    endcase
  endfunction

  // Strobe monitor / scoreboard
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        mon_e = exp_q.pop_front();
        tests_run++;
        tests_failed++;
        $display("FAIL missed_strobe: got none expected %b at edge %0d", mon_e.val, mon_e.at);
      end
      if (keypad !== 10'b0) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_strobe: got %b at edge %0d expected 0", keypad, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_value", {22'b0, keypad}, {22'b0, mon_e.val});
          check("strobe_edge", cyc, mon_e.at);
        end
      end
    end
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{10'b0000001000, 50, 10'b0000001000, 1'b0};
    vecs[1] = '{10'b0000000001, 12, 10'b0000000001, 1'b0};
    vecs[2] = '{10'b1000000000,  8, 10'b1000000000, 1'b0};
    vecs[3] = '{10'b0001000000,  4, 10'b0001000000, 1'b0};
    vecs[4] = '{10'b0000100000,  3, 10'b0000000000, 1'b0};
    vecs[5] = '{10'b0000010010, 12, 10'b0000000000, 1'b1};
    vecs[6] = '{10'b0000000111, 10, 10'b0000000000, 1'b1};
    vecs[7] = '{10'b0000000000, 10, 10'b0000000000, 1'b0};

    // Reset with digit 5 held: no strobe during reset, strobe 7 edges after release.
    reset = 1'b1;
    key_raw = 10'b0000100000;
    start_raw = 1'b0; stop_raw = 1'b0; clear_raw = 1'b0;
    step(3);
    mon_en = 1'b1;
    check("rst_keypad", {22'b0, keypad}, 32'd0);
    check("rst_startn", startn, 1);
    check("rst_stopn",  stopn,  1);
    check("rst_clearn", clearn, 1);
    check("rst_multi",  multi_key, 0);
    step(5);
    reset = 1'b0;
    expect_strobe(10'b0000100000);
    step(12);
    key_raw = '0;
    step(10);

    // Reset mid-debounce discards progress; held key re-debounces from zero.
    key_raw = 10'b0000001000;
    step(5);
    reset = 1'b1;
    step(2);
    check("midrst_multi", multi_key, 0);
    reset = 1'b0;
    expect_strobe(10'b0000001000);
    step(12);
    key_raw = '0;
    step(10);

    // Table-driven press patterns, each from idle and followed by full release.
    for (int i = 0; i < 8; i++) begin
      key_raw = vecs[i].keys;
      if (vecs[i].exp_strobe != 10'b0) expect_strobe(vecs[i].exp_strobe);
      step(vecs[i].hold);
      check($sformatf("vec%0d_multi_held", i), multi_key, vecs[i].exp_multi);
      key_raw = '0;
      step(10);
      check($sformatf("vec%0d_multi_released", i), multi_key, 0);
    end

    // Bouncing digit 7: no strobe while toggling, one strobe after it settles.
    for (int i = 0; i < 5; i++) begin
      key_raw = 10'b0010000000;
      step(2);
      key_raw = 10'b0000000000;
      step(2);
    end
    key_raw = 10'b0010000000;
    expect_strobe(10'b0010000000);
    step(12);
    key_raw = '0;
    step(10);

    // Digit 2 accepted, then 9 added: lockout until full release; 9 alone then accepted.
    key_raw = 10'b0000000100;
    expect_strobe(10'b0000000100);
    step(10);
    key_raw = 10'b1000000100;
    step(10);
    check("add9_multi", multi_key, 1);
    key_raw = 10'b1000000000;
    step(10);
    check("drop2_still_lock", multi_key, 1);
    key_raw = '0;
    step(10);
    check("release_all_multi", multi_key, 0);
    key_raw = 10'b1000000000;
    expect_strobe(10'b1000000000);
    step(10);
    key_raw = '0;
    step(10);

    // Digits 1 and 4 together, release 4 only: still locked out, no strobe.
    key_raw = 10'b0000010010;
    step(10);
    check("pair_multi", multi_key, 1);
    key_raw = 10'b0000000010;
    step(10);
    check("pair_drop4_multi", multi_key, 1);
    key_raw = '0;
    step(10);
    check("pair_release_multi", multi_key, 0);

    // Buttons: short pulse filtered; 10-cycle hold falls at +6 and returns 6 after release.
    for (int b = 0; b < 3; b++) begin
      int k;
      set_btn(b, 1'b1);
      for (int t = 1; t <= 10; t++) begin
        step(1);
        if (t == 3) set_btn(b, 1'b0);
        check($sformatf("btn%0d_pulse_t%0d", b, t), btn_n(b), 1);
      end
      k = cyc;
      set_btn(b, 1'b1);
      key_raw = 10'b0000000001 << b;
      expect_strobe(10'b0000000001 << b);
      for (int t = 1; t <= 20; t++) begin
        step(1);
        check($sformatf("btn%0d_hold_t%0d", b, cyc - k), btn_n(b),
              ((t >= 6) && (t < 16)) ? 0 : 1);
        if (t == 10) begin
          set_btn(b, 1'b0);
          key_raw = '0;
        end
      end
      step(4);
    end

    step(20);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
